config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Upstream feeder for the serial configuration chain of a CGRA tile, such as a register-file block whose ConfigCell stages are daisy-chained ConfigIn->ConfigOut.
- Accepts the configuration bitstream as WORD_W-bit words over a valid/ready handshake.
- Serialises exactly CHAIN_LEN bits into the chain head, with a shift-enable that gates chain advance.
- Reports busy/done and, optionally, a CRC-based readback check via the chain tail.

Parameters:
CHAIN_LEN, 4, total config bits in the chain (>=1)
WORD_W, 32, bitstream word width (>=1)

Ports:
Config_Clock  input  1  config clock; all state on rising edge
Config_Reset  input  1  asynchronous, active-low reset
start  input  1  begin a load; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE next cycle from any state
word_in  input  WORD_W  bitstream word, bit 0 shifted first
word_valid  input  1  word_in valid
word_ready  output  1  loader accepts word this cycle
cfg_out  output  1  serial data to chain head ConfigIn
cfg_shift_en  output  1  chain advances one bit this cycle (clock-enable for all chain cells)
cfg_tail_in  input  1  ConfigOut of chain tail (used only with readback)
busy  output  1  high in every state except IDLE/DONE
done  output  1  level; high in DONE until next accepted start
crc_err  output  1  readback mismatch (held until next accepted start; 0 when feature off)

Behaviour:
- Reset (Config_Reset=0, async): state=IDLE, word_ready=0, cfg_out=0, cfg_shift_en=0, busy=0, done=0, crc_err=0, counters=0.
- States: IDLE, FETCH, SHIFT, VERIFY (feature only), DONE.
- IDLE/DONE + start=1 -> FETCH; clears done and crc_err; bit_cnt=0.
- FETCH:
  - word_ready=1, cfg_shift_en=0, so the chain holds.
  - On word_valid&&word_ready, latch word_in into the shift reg, word_bits=min(WORD_W, CHAIN_LEN-bit_cnt), -> SHIFT.
  - No combinational path valid->ready.
- SHIFT (one bit per cycle):
  - cfg_shift_en=1, cfg_out=sreg[0]; sreg>>=1, bit_cnt++.
  - When the word's bits are exhausted: bit_cnt==CHAIN_LEN -> VERIFY (feature) or DONE; else -> FETCH.
  - Excess bits of the final partial word are discarded.
  - Latency from word acceptance to first shift: 1 cycle. One-cycle bubble (shift_en=0) per word boundary.
- Bit ordering: stream bit i enters the chain at shift i. After CHAIN_LEN shifts, stream bit CHAIN_LEN-1 sits in the head cell and bit 0 in the tail cell.
- cfg_shift_en total high cycles per load = CHAIN_LEN exactly.
- cfg_out=0 whenever cfg_shift_en=0.
- abort:
  - Takes priority over all transitions.
  - -> IDLE, shift_en=0, done=0, word_ready=0. Any word offered in the abort cycle is not accepted.
  - Chain contents are then partial and undefined.
- start while busy: ignored.
- word_valid outside FETCH: ignored.
- bit_cnt width clog2(CHAIN_LEN+1); no wrap permitted.

Optional Feature:
- Macro: CFG_READBACK_CHECK_EN.
- Defined:
  - During SHIFT, a CRC-16-CCITT (poly 0x1021, init 0xFFFF, bit-serial, MSB-first register) accumulates every cfg_out bit shifted.
  - VERIFY runs CHAIN_LEN cycles with cfg_shift_en=1 and cfg_out=cfg_tail_in (recirculate), so the chain ends unchanged.
  - A second CRC (same init) accumulates cfg_tail_in.
  - At exit, crc_err=(crc_a!=crc_b), then -> DONE. Abort in VERIFY -> IDLE with crc_err=0.
- Undefined: no VERIFY state, no CRC logic, crc_err tied 0, cfg_tail_in unused; SHIFT -> DONE directly.

Test Plan:
1. CHAIN_LEN=4, WORD_W=32: start, word 0x0000000B -> cfg_out stream 1,1,0,1 across 4 shift_en cycles; head..tail cells = 1,0,1,1; done=1, busy=0 next cycle.
2. CHAIN_LEN=70, WORD_W=32: words 0xFFFFFFFF, 0x00000000, 0x0000002A, with valid held high -> 3 handshakes, 70 shift_en cycles, 2 bubbles, last 6 bits 0,1,0,1,0,1, done at 73rd cycle after first accept.
3. Delay word_valid 5 cycles mid-load -> shift_en stays 0 and chain holds; bit count still 70; no extra handshakes.
4. Assert abort on 3rd SHIFT cycle of scenario 1 -> IDLE next cycle, done=0, shift_en=0. Restart completes normally.
5. Pulse start while busy, and word_valid in IDLE -> ignored; word_ready stays 0 outside FETCH.
6. (CFG_READBACK_CHECK_EN) Model chain as a 4-bit shifter; crc_err=0 after load + 4 recirculate cycles. Flip one model bit during VERIFY -> crc_err=1 in DONE.

Source files
------------

// File: rtl/config_chain_loader.sv
// Word stream to serial CGRA config chain: 1 cycle from word accept to first shift, one idle cycle per word boundary.
// word_ready depends only on state and abort, never on word_valid. Define CFG_READBACK_CHECK_EN for the CRC readback pass.
module config_chain_loader #(
   parameter int CHAIN_LEN = 4,
   parameter int WORD_W    = 32
) (
   input  logic              Config_Clock,
   input  logic              Config_Reset,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              cfg_out,
   output logic              cfg_shift_en,
   input  logic              cfg_tail_in,
   output logic              busy,
   output logic              done,
   output logic              crc_err
);
   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int BW = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SHIFT, S_VERIFY, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [BW-1:0]     rem_q, rem_d;
   logic [31:0]       chain_left;
   logic [BW-1:0]     word_bits;

   // The final word may carry more bits than the chain still needs; the excess is never shifted.
   assign chain_left = 32'(CHAIN_LEN) - 32'(bit_cnt_q);
   assign word_bits  = (chain_left < 32'(WORD_W)) ? BW'(chain_left) : BW'(WORD_W);

`ifdef CFG_READBACK_CHECK_EN
   logic [15:0] crc_a_q, crc_a_d, crc_b_q, crc_b_d;
   logic        crc_err_q, crc_err_d;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ din) == 1'b1) ? 16'h1021 : 16'h0000);
   endfunction

   assign crc_err = crc_err_q;
`else
   logic unused_tail;
   assign unused_tail = cfg_tail_in;
   assign crc_err     = 1'b0;
`endif

   assign busy = (state_q == S_FETCH) || (state_q == S_SHIFT) || (state_q == S_VERIFY);
   assign done = (state_q == S_DONE);

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      bit_cnt_d    = bit_cnt_q;
      rem_d        = rem_q;
      word_ready   = 1'b0;
      cfg_shift_en = 1'b0;
      cfg_out      = 1'b0;
`ifdef CFG_READBACK_CHECK_EN
      crc_a_d      = crc_a_q;
      crc_b_d      = crc_b_q;
      crc_err_d    = crc_err_q;
`endif
      if (abort) begin
         // Abort also suppresses the shift and the handshake of the current cycle.
         state_d = S_IDLE;
`ifdef CFG_READBACK_CHECK_EN
         if (state_q == S_VERIFY) crc_err_d = 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d   = S_FETCH;
                  bit_cnt_d = '0;
`ifdef CFG_READBACK_CHECK_EN
                  crc_a_d   = 16'hFFFF;
                  crc_b_d   = 16'hFFFF;
                  crc_err_d = 1'b0;
`endif
               end
            end
            S_FETCH: begin
               word_ready = 1'b1;
               if (word_valid) begin
                  sreg_d  = word_in;
                  rem_d   = word_bits;
                  state_d = S_SHIFT;
               end
            end
            S_SHIFT: begin
               cfg_shift_en = 1'b1;
               cfg_out      = sreg_q[0];
               sreg_d       = sreg_q >> 1;
               bit_cnt_d    = bit_cnt_q + CW'(1);
               rem_d        = rem_q - BW'(1);
`ifdef CFG_READBACK_CHECK_EN
               crc_a_d      = crc16_step(crc_a_q, sreg_q[0]);
`endif
               if (rem_q == BW'(1)) begin
                  if (bit_cnt_q == CW'(CHAIN_LEN - 1)) begin
`ifdef CFG_READBACK_CHECK_EN
                     state_d   = S_VERIFY;
                     bit_cnt_d = '0;
`else
                     state_d   = S_DONE;
`endif
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            end
`ifdef CFG_READBACK_CHECK_EN
            S_VERIFY: begin
               // Tail fed back into the head: after CHAIN_LEN cycles the chain is restored.
               cfg_shift_en = 1'b1;
               cfg_out      = cfg_tail_in;
               bit_cnt_d    = bit_cnt_q + CW'(1);
               crc_b_d      = crc16_step(crc_b_q, cfg_tail_in);
               if (bit_cnt_q == CW'(CHAIN_LEN - 1)) begin
                  state_d   = S_DONE;
                  crc_err_d = (crc_b_d != crc_a_q);
               end
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Config_Clock or negedge Config_Reset) begin
      if (!Config_Reset) begin
         state_q   <= S_IDLE;
         sreg_q    <= '0;
         bit_cnt_q <= '0;
         rem_q     <= '0;
`ifdef CFG_READBACK_CHECK_EN
         crc_a_q   <= 16'hFFFF;
         crc_b_q   <= 16'hFFFF;
         crc_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
         rem_q     <= rem_d;
`ifdef CFG_READBACK_CHECK_EN
         crc_a_q   <= crc_a_d;
         crc_b_q   <= crc_b_d;
         crc_err_q <= crc_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 4-cell and a 70-cell chain driven by two loader instances,
// a bit-queue model of the expected stream, and bench-side chain shifters fed by the DUT outputs.
module tb_config_chain_loader;
   localparam int W    = 32;
   localparam int NMAX = 70;
`ifdef CFG_READBACK_CHECK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif

   int lens [2] = '{4, 70};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         st [2];
   logic         ab [2];
   logic         wv [2];
   logic [W-1:0] wd [2];
   logic         rdy [2];
   logic         sh [2];
   logic         co [2];
   logic         tl [2];
   logic         bsy [2];
   logic         dn [2];
   logic         ce [2];
   logic         flip = 1'b0;

   config_chain_loader #(.CHAIN_LEN(4), .WORD_W(W)) u_short (
      .Config_Clock(clk), .Config_Reset(rst_n), .start(st[0]), .abort(ab[0]),
      .word_in(wd[0]), .word_valid(wv[0]), .word_ready(rdy[0]), .cfg_out(co[0]),
      .cfg_shift_en(sh[0]), .cfg_tail_in(tl[0]), .busy(bsy[0]), .done(dn[0]), .crc_err(ce[0]));

   config_chain_loader #(.CHAIN_LEN(70), .WORD_W(W)) u_long (
      .Config_Clock(clk), .Config_Reset(rst_n), .start(st[1]), .abort(ab[1]),
      .word_in(wd[1]), .word_valid(wv[1]), .word_ready(rdy[1]), .cfg_out(co[1]),
      .cfg_shift_en(sh[1]), .cfg_tail_in(tl[1]), .busy(bsy[1]), .done(dn[1]), .crc_err(ce[1]));

   // Chain cells: index 0 is the head, lens[i]-1 the tail.
   logic chain [2][NMAX] = '{default: 1'b0};
   assign tl[0] = chain[0][3];
   assign tl[1] = chain[1][69];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (sh[i] === 1'b1) begin
            for (int j = NMAX - 1; j > 0; j--) chain[i][j] <= chain[i][j-1];
            chain[i][0] <= co[i];
            if (i == 0 && flip) chain[0][3] <= ~chain[0][2];
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model state: bits still owed to the chain, bits left in the current word, readback cycles left.
   logic            m_load [2];
   logic            m_done [2];
   logic            m_err  [2];
   int              m_need [2];
   int              m_left [2];
   int              m_pos  [2];
   int              m_vleft[2];
   logic [W-1:0]    m_word [2];
   logic [NMAX-1:0] m_sent [2];
   logic [NMAX-1:0] m_back [2];

   logic capbits [2][4096];
   int   nsh [2];
   int   nhs [2];
   int   acc_cyc [2];
   int   last_sh [2];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_cycle();
      for (int i = 0; i < 2; i++) begin
         int    n;
         logic  e_sh, e_out, e_rdy;
         string tag;
         n   = lens[i];
         tag = (i == 0) ? "short" : "long";
         if (!rst_n) begin
            m_load[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0;
            m_need[i] = 0; m_left[i] = 0; m_pos[i] = 0; m_vleft[i] = 0;
         end else begin
            e_sh  = !ab[i] && (m_left[i] > 0 || m_vleft[i] > 0);
            e_out = e_sh && ((m_left[i] > 0) ? m_word[i][m_pos[i]] : tl[i]);
            e_rdy = !ab[i] && m_load[i] && m_left[i] == 0 && m_vleft[i] == 0 && m_need[i] > 0;
            chk({"word_ready.", tag}, int'(rdy[i]), int'(e_rdy));
            chk({"shift_en.", tag},   int'(sh[i]),  int'(e_sh));
            chk({"cfg_out.", tag},    int'(co[i]),  int'(e_out));
            chk({"busy.", tag},       int'(bsy[i]), int'(m_load[i]));
            chk({"done.", tag},       int'(dn[i]),  int'(m_done[i]));
            chk({"crc_err.", tag},    int'(ce[i]),  int'(m_err[i]));
            if (sh[i] === 1'b1) begin
               if (nsh[i] < 4096) capbits[i][nsh[i]] = co[i];
               nsh[i]++;
               last_sh[i] = cyc;
            end
            if (rdy[i] === 1'b1 && wv[i]) begin
               nhs[i]++;
               acc_cyc[i] = cyc;
            end
            if (ab[i]) begin
               m_load[i] = 1'b0; m_done[i] = 1'b0;
               m_need[i] = 0; m_left[i] = 0; m_vleft[i] = 0;
            end else if (!m_load[i]) begin
               if (st[i]) begin
                  m_load[i] = 1'b1; m_done[i] = 1'b0; m_err[i] = 1'b0;
                  m_need[i] = n; m_sent[i] = '0; m_back[i] = '0;
               end
            end else if (m_left[i] > 0) begin
               m_sent[i][n - m_need[i]] = m_word[i][m_pos[i]];
               m_pos[i]++; m_left[i]--; m_need[i]--;
               if (m_left[i] == 0 && m_need[i] == 0) begin
                  if (RB == 1) m_vleft[i] = n;
                  else begin m_load[i] = 1'b0; m_done[i] = 1'b1; end
               end
            end else if (m_vleft[i] > 0) begin
               m_back[i][n - m_vleft[i]] = tl[i];
               m_vleft[i]--;
               if (m_vleft[i] == 0) begin
                  m_load[i] = 1'b0; m_done[i] = 1'b1;
                  m_err[i]  = (m_back[i] != m_sent[i]);
               end
            end else if (wv[i]) begin
               m_word[i] = wd[i];
               m_pos[i]  = 0;
               m_left[i] = (m_need[i] < W) ? m_need[i] : W;
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic pulse_start(input int i);
      st[i] = 1'b1;
      step();
      st[i] = 1'b0;
   endtask

   task automatic send(input int i, input logic [W-1:0] w);
      bit ok;
      ok    = 1'b0;
      wd[i] = w;
      wv[i] = 1'b1;
      for (int k = 0; k < 200 && !ok; k++) begin
         if (rdy[i] === 1'b1) ok = 1'b1;
         step();
      end
      wv[i] = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_done(input int i);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         if (dn[i] === 1'b1) ok = 1'b1;
         else step();
      end
      if (!ok) chk("done_timeout", 0, 1);
   endtask

   function automatic int stream_val(input int i, input int base, input int cnt);
      int v;
      v = 0;
      for (int k = 0; k < cnt; k++) v |= int'(capbits[i][base + k]) << k;
      return v;
   endfunction

   function automatic int short_chain();
      int v;
      v = 0;
      for (int j = 0; j < 4; j++) v = (v << 1) | int'(chain[0][j]);
      return v;
   endfunction

   function automatic int long_chain_mism();
      logic [NMAX-1:0] exp;
      logic [W-1:0]    w3;
      int              m;
      w3 = 32'h0000002A;
      for (int k = 0; k < NMAX; k++) exp[k] = (k < 32) ? 1'b1 : (k < 64) ? 1'b0 : w3[k - 64];
      m = 0;
      for (int j = 0; j < NMAX; j++) if (chain[1][j] !== exp[NMAX - 1 - j]) m++;
      return m;
   endfunction

   initial begin
      int b, h, a0, t;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         st[i] = 1'b0; ab[i] = 1'b0; wv[i] = 1'b0; wd[i] = '0;
         nsh[i] = 0; nhs[i] = 0; acc_cyc[i] = 0; last_sh[i] = 0;
      end
      repeat (3) step();
      chk("rst_word_ready", int'(rdy[0]) + int'(rdy[1]), 0);
      chk("rst_shift_en",   int'(sh[0]) + int'(sh[1]), 0);
      chk("rst_cfg_out",    int'(co[0]) + int'(co[1]), 0);
      chk("rst_busy",       int'(bsy[0]) + int'(bsy[1]), 0);
      chk("rst_done",       int'(dn[0]) + int'(dn[1]), 0);
      chk("rst_crc_err",    int'(ce[0]) + int'(ce[1]), 0);
      rst_n = 1'b1;
      step();

      // Single word into the 4-cell chain.
      b = nsh[0];
      pulse_start(0);
      send(0, 32'h0000000B);
      wait_done(0);
      chk("t1_done_latency", cyc - acc_cyc[0], 5 + 4 * RB);
      chk("t1_busy_in_done", int'(bsy[0]), 0);
      chk("t1_stream", stream_val(0, b, 4), 32'hB);
      chk("t1_chain_head_to_tail", short_chain(), 4'b1011);
      chk("t1_shift_count", nsh[0] - b, 4 * (1 + RB));
      chk("t1_crc_err", int'(ce[0]), 0);

      // Three words back to back into the 70-cell chain.
      b = nsh[1]; h = nhs[1];
      pulse_start(1);
      send(1, 32'hFFFFFFFF);
      a0 = acc_cyc[1];
      send(1, 32'h00000000);
      send(1, 32'h0000002A);
      wait_done(1);
      chk("t2_handshakes", nhs[1] - h, 3);
      chk("t2_shift_count", nsh[1] - b, 70 * (1 + RB));
      chk("t2_bubbles", (last_sh[1] - a0) - (nsh[1] - b), 2);
      chk("t2_last6", stream_val(1, b + 64, 6), 6'b101010);
      chk("t2_done_cycle", cyc - a0, 73 + 70 * RB);
      chk("t2_chain", long_chain_mism(), 0);

      // Same load with a five-cycle gap before the second word.
      b = nsh[1]; h = nhs[1];
      pulse_start(1);
      send(1, 32'hFFFFFFFF);
      a0 = acc_cyc[1];
      repeat (32) step();
      t = nsh[1];
      repeat (5) step();
      chk("t3_stall_no_shift", nsh[1] - t, 0);
      chk("t3_stall_ready", int'(rdy[1]), 1);
      send(1, 32'h00000000);
      send(1, 32'h0000002A);
      wait_done(1);
      chk("t3_handshakes", nhs[1] - h, 3);
      chk("t3_shift_count", nsh[1] - b, 70 * (1 + RB));
      chk("t3_done_cycle", cyc - a0, 78 + 70 * RB);
      chk("t3_chain", long_chain_mism(), 0);

      // Abort on the third shift, then a clean reload.
      b = nsh[0];
      pulse_start(0);
      send(0, 32'h0000000B);
      step();
      step();
      ab[0] = 1'b1;
      step();
      ab[0] = 1'b0;
      chk("t4_busy_after_abort", int'(bsy[0]), 0);
      chk("t4_done_after_abort", int'(dn[0]), 0);
      chk("t4_shift_after_abort", int'(sh[0]), 0);
      chk("t4_shifts_before_abort", nsh[0] - b, 2);
      pulse_start(0);
      send(0, 32'h0000000B);
      wait_done(0);
      chk("t4_reload_chain", short_chain(), 4'b1011);

      // Abort from DONE, word_valid while idle, start while busy, word_valid in DONE.
      ab[0] = 1'b1;
      step();
      ab[0] = 1'b0;
      h = nhs[0];
      wd[0] = 32'hFFFFFFFF;
      wv[0] = 1'b1;
      repeat (3) step();
      chk("t5_idle_ready", int'(rdy[0]), 0);
      wv[0] = 1'b0;
      chk("t5_idle_handshakes", nhs[0] - h, 0);
      pulse_start(0);
      send(0, 32'h00000005);
      st[0] = 1'b1;
      step();
      step();
      st[0] = 1'b0;
      wait_done(0);
      chk("t5_busy_start_latency", cyc - acc_cyc[0], 5 + 4 * RB);
      chk("t5_chain", short_chain(), 4'b0101);
      h = nhs[0];
      wv[0] = 1'b1;
      repeat (2) step();
      wv[0] = 1'b0;
      chk("t5_done_handshakes", nhs[0] - h, 0);
      chk("t5_done_held", int'(dn[0]), 1);

`ifdef CFG_READBACK_CHECK_EN
      // Readback: clean pass, then one chain bit corrupted during recirculation.
      pulse_start(0);
      send(0, 32'h0000000B);
      wait_done(0);
      chk("t6_clean_crc_err", int'(ce[0]), 0);
      chk("t6_clean_chain", short_chain(), 4'b1011);
      pulse_start(0);
      send(0, 32'h0000000B);
      repeat (4) step();
      flip = 1'b1;
      step();
      flip = 1'b0;
      wait_done(0);
      chk("t6_flip_crc_err", int'(ce[0]), 1);
`endif

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
